// File: rtl/wb_arbiter_if.sv
// Writeback bus between the three result producers, the arbiter and the
// register file write port.
interface wb_arbiter_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_addr;
  logic [XLEN-1:0]       alu_data;

  logic                  mem_valid;
  logic                  mem_ready;
  logic [REG_ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]       mem_data;

  logic                  md_valid;
  logic                  md_ready;
  logic [REG_ADDR_W-1:0] md_addr;
  logic [XLEN-1:0]       md_data;

  logic                  write_en;
  logic [REG_ADDR_W-1:0] write_addr;
  logic [XLEN-1:0]       write_data;
  logic                  busy;

  // Producer / register-file side.
  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    output md_valid,  md_addr,  md_data,
    input  alu_ready, mem_ready, md_ready,
    input  write_en, write_addr, write_data, busy
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    input  md_valid,  md_addr,  md_data,
    output alu_ready, mem_ready, md_ready,
    output write_en, write_addr, write_data, busy
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: fixed priority (alu > mem > md) with age-based
// anti-starvation, driving the register file write port from a register.
module wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  localparam int unsigned NREQ = 3;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_MD   = 2'd2,
    SRC_NONE = 2'd3
  } src_e;

  logic [NREQ-1:0]       valid;
  logic [NREQ-1:0]       is_x0;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       starved;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       ready;
  logic [REG_ADDR_W-1:0] addr [NREQ];
  logic [XLEN-1:0]       data [NREQ];
  logic [3:0]            age  [NREQ];
  src_e                  winner;
  logic [REG_ADDR_W-1:0] win_addr;
  logic [XLEN-1:0]       win_data;

  assign valid   = {bus.md_valid, bus.mem_valid, bus.alu_valid};
  assign addr[0] = bus.alu_addr;
  assign addr[1] = bus.mem_addr;
  assign addr[2] = bus.md_addr;
  assign data[0] = bus.alu_data;
  assign data[1] = bus.mem_data;
  assign data[2] = bus.md_data;

  always_comb begin
    is_x0   = '0;
    req     = '0;
    starved = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      is_x0[i]   = valid[i] && (addr[i] == '0);
      req[i]     = valid[i] && (addr[i] != '0);
      starved[i] = req[i] && (age[i] >= LIMIT);
    end
  end

  // Any starved requester pre-empts the fixed order; ties go to the lower index.
  always_comb begin
    winner = SRC_NONE;
    if (|starved) begin
      if (starved[0])      winner = SRC_ALU;
      else if (starved[1]) winner = SRC_MEM;
      else                 winner = SRC_MD;
    end else begin
      if (req[0])      winner = SRC_ALU;
      else if (req[1]) winner = SRC_MEM;
      else if (req[2]) winner = SRC_MD;
    end
  end

  always_comb begin
    grant    = '0;
    win_addr = '0;
    win_data = '0;
    case (winner)
      SRC_ALU: begin grant = 3'b001; win_addr = addr[0]; win_data = data[0]; end
      SRC_MEM: begin grant = 3'b010; win_addr = addr[1]; win_data = data[1]; end
      SRC_MD:  begin grant = 3'b100; win_addr = addr[2]; win_data = data[2]; end
      default: begin grant = '0; end
    endcase
  end

  // x0 writes are acknowledged outside arbitration; nothing is accepted in reset.
  assign ready         = rst ? '0 : (is_x0 | grant);
  assign bus.alu_ready = ready[0];
  assign bus.mem_ready = ready[1];
  assign bus.md_ready  = ready[2];
  assign bus.busy      = |(valid & ~ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREQ; i++) age[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!valid[i] || ready[i]) age[i] <= '0;
        else if (age[i] < LIMIT)   age[i] <= age[i] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.write_en   <= 1'b0;
      bus.write_addr <= '0;
      bus.write_data <= '0;
    end else begin
      bus.write_en <= (winner != SRC_NONE);
      if (winner != SRC_NONE) begin
        bus.write_addr <= win_addr;
        bus.write_data <= win_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios followed by random traffic, all
// checked against a behavioural model of the arbitration rules.
module tb_wb_arbiter;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int SL   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_arbiter_if #(.XLEN(XLEN), .REG_ADDR_W(AW)) bus ();

  wb_arbiter #(.XLEN(XLEN), .REG_ADDR_W(AW), .STARVE_LIMIT(SL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Producer-side request state
  logic            v [3];
  logic [AW-1:0]   a [3];
  logic [XLEN-1:0] d [3];

  // Model state
  int              wait_m [3];
  logic            ew;
  logic [AW-1:0]   ea;
  logic [XLEN-1:0] ed;
  logic [2:0]      exp_rdy;
  logic [2:0]      obs_rdy;
  logic            obs_busy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.alu_valid = v[0]; bus.alu_addr = a[0]; bus.alu_data = d[0];
    bus.mem_valid = v[1]; bus.mem_addr = a[1]; bus.mem_data = d[1];
    bus.md_valid  = v[2]; bus.md_addr  = a[2]; bus.md_data  = d[2];
  endtask

  // One clock: check combinational outputs, advance model, check registered outputs.
  task automatic step(input string tag);
    int   win;
    int   best;
    int   key;
    logic eb;
    drive();
    #1;
    win  = -1;
    best = 99;
    for (int i = 0; i < 3; i++) begin
      if (v[i] && a[i] != 0) begin
        key = (wait_m[i] >= SL) ? i : i + 3;
        if (key < best) begin best = key; win = i; end
      end
    end
    eb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_rdy[i] = !rst && ((v[i] && a[i] == 0) || win == i);
      eb = eb | (v[i] && !exp_rdy[i]);
    end
    obs_rdy  = {bus.md_ready, bus.mem_ready, bus.alu_ready};
    obs_busy = bus.busy;
    chk({tag, ".alu_ready"}, 64'(obs_rdy[0]), 64'(exp_rdy[0]));
    chk({tag, ".mem_ready"}, 64'(obs_rdy[1]), 64'(exp_rdy[1]));
    chk({tag, ".md_ready"},  64'(obs_rdy[2]), 64'(exp_rdy[2]));
    chk({tag, ".busy"},      64'(obs_busy),   64'(eb));
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 3; i++) wait_m[i] = 0;
      ew = 1'b0; ea = '0; ed = '0;
    end else begin
      for (int i = 0; i < 3; i++)
        wait_m[i] = (!v[i] || exp_rdy[i]) ? 0 : ((wait_m[i] < SL) ? wait_m[i] + 1 : SL);
      ew = (win >= 0);
      if (win >= 0) begin ea = a[win]; ed = d[win]; end
    end
    #1;
    chk({tag, ".write_en"},   64'(bus.write_en),   64'(ew));
    chk({tag, ".write_addr"}, 64'(bus.write_addr), 64'(ea));
    chk({tag, ".write_data"}, 64'(bus.write_data), 64'(ed));
  endtask

  task automatic drop_accepted();
    for (int i = 0; i < 3; i++) if (exp_rdy[i]) v[i] = 1'b0;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 3; i++) begin v[i] = 1'b0; a[i] = '0; d[i] = '0; end
  endtask

  initial begin
    logic [2:0] md_seen;
    logic       busy_seen [3];
    for (int i = 0; i < 3; i++) wait_m[i] = 0;
    ew = 1'b0; ea = '0; ed = '0; exp_rdy = '0;
    clear_all();
    rst = 1'b1;
    step("reset0");
    step("reset1");
    chk("reset.write_en", 64'(bus.write_en), 64'd0);
    chk("reset.write_addr", 64'(bus.write_addr), 64'd0);
    rst = 1'b0;

    // Single ALU request
    v[0] = 1'b1; a[0] = 5'd5; d[0] = 32'hDEADBEEF;
    step("single.c0");
    chk("single.ready_c0", 64'(obs_rdy[0]), 64'd1);
    chk("single.we_c1", 64'(bus.write_en), 64'd1);
    chk("single.addr_c1", 64'(bus.write_addr), 64'd5);
    chk("single.data_c1", 64'(bus.write_data), 64'hDEADBEEF);
    drop_accepted();
    step("single.c1");
    chk("single.we_c2", 64'(bus.write_en), 64'd0);

    // All three at once
    for (int i = 0; i < 3; i++) begin
      v[i] = 1'b1; a[i] = 5'(i + 1); d[i] = 32'h1000 + 32'(i);
    end
    for (int c = 0; c < 3; c++) begin
      step($sformatf("three.c%0d", c));
      busy_seen[c] = obs_busy;
      chk($sformatf("three.grant_c%0d", c), 64'(obs_rdy), 64'(3'b001 << c));
      chk($sformatf("three.waddr_c%0d", c), 64'(bus.write_addr), 64'(c + 1));
      drop_accepted();
    end
    chk("three.busy_c0", 64'(busy_seen[0]), 64'd1);
    chk("three.busy_c1", 64'(busy_seen[1]), 64'd1);
    chk("three.busy_c2", 64'(busy_seen[2]), 64'd0);
    step("three.idle");

    // Starvation: alu always valid with fresh addresses, md waiting on addr 7
    v[0] = 1'b1; a[0] = 5'd10; d[0] = $urandom;
    v[2] = 1'b1; a[2] = 5'd7;  d[2] = 32'hCAFE0007;
    md_seen = '0;
    for (int c = 0; c < 6; c++) begin
      step($sformatf("starve.c%0d", c));
      if (c < 4) chk($sformatf("starve.md_wait_c%0d", c), 64'(obs_rdy[2]), 64'd0);
      if (c == 4) begin
        chk("starve.md_ready_c4", 64'(obs_rdy[2]), 64'd1);
        chk("starve.alu_held_c4", 64'(obs_rdy[0]), 64'd0);
        chk("starve.write7_c5", 64'(bus.write_addr), 64'd7);
      end
      if (c == 5) chk("starve.alu_resume_c5", 64'(obs_rdy[0]), 64'd1);
      if (exp_rdy[0]) begin a[0] = 5'(11 + c); d[0] = $urandom; end
      if (exp_rdy[2]) v[2] = 1'b0;
    end
    clear_all();
    step("starve.idle");

    // x0 drop alongside a real write
    v[1] = 1'b1; a[1] = 5'd0; d[1] = 32'h55555555;
    v[0] = 1'b1; a[0] = 5'd9; d[0] = 32'h00000009;
    step("x0.c0");
    chk("x0.both_ready", 64'(obs_rdy[1:0]), 64'd3);
    chk("x0.addr9", 64'(bus.write_addr), 64'd9);
    clear_all();
    v[1] = 1'b1; a[1] = 5'd0;
    step("x0.alone");
    chk("x0.no_we", 64'(bus.write_en), 64'd0);
    clear_all();
    step("x0.idle");

    // Reset mid-operation with md at age 3
    v[0] = 1'b1; a[0] = 5'd12; d[0] = 32'h12;
    v[2] = 1'b1; a[2] = 5'd13; d[2] = 32'h13;
    for (int c = 0; c < 3; c++) step($sformatf("rstmid.c%0d", c));
    rst = 1'b1;
    step("rstmid.rst");
    chk("rstmid.md_rdy", 64'(obs_rdy[2]), 64'd0);
    chk("rstmid.we_after", 64'(bus.write_en), 64'd0);
    rst = 1'b0;
    step("rstmid.after");
    chk("rstmid.md_not_starved", 64'(obs_rdy[2]), 64'd0);
    clear_all();
    step("rstmid.idle");

    // Idle
    for (int c = 0; c < 10; c++) begin
      step($sformatf("idle.c%0d", c));
      chk($sformatf("idle.rdy_c%0d", c), 64'(obs_rdy), 64'd0);
    end

    // Random traffic; producers hold requests until accepted
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 3; i++) begin
        if (!v[i] || exp_rdy[i]) begin
          if ($urandom_range(0, 3) != 0) begin
            v[i] = 1'b1;
            a[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            d[i] = $urandom;
          end else begin
            v[i] = 1'b0;
          end
        end
      end
      step($sformatf("rand.c%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
